lru_evict_ctrl: RTL
===================

# lru_evict_ctrl

Miss-side controller for the 8-way set-associative cache. It consumes the victim way published by the pLRU tree, keeps per-set valid and dirty bits, and sequences eviction: optional writeback of a dirty victim, then line fill. On install, and on every hit, it drives the pLRU tree's update port. It sits between the cache datapath (hit and miss signals) and the memory-side handshake.

## Interface
Parameters:
- s_index, 3, set index width; 2**s_index sets, 8 ways fixed (3-bit way id)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous reset, active-low (0 = reset)
- req  in  1  miss request; held high until done
- req_index  in  s_index  set of the miss; sampled in IDLE when req accepted
- req_write  in  1  miss is a store; installed line marked dirty
- hit  in  1  single-cycle hit pulse
- hit_index  in  s_index  set of the hit
- hit_way  in  3  way that hit
- hit_write  in  1  hit is a store; sets dirty[hit_index][hit_way]
- plru  in  3  victim way from pLRU tree for lru_index
- lru_load  out  1  pLRU update strobe
- lru_index  out  s_index  set addressed at the pLRU tree
- lru_access  out  3  way just accessed
- wb_req  out  1  writeback request, level
- wb_ack  in  1  writeback complete
- fill_req  out  1  fill request, level
- fill_ack  in  1  fill complete
- mem_way  out  3  victim way for wb/fill datapath
- mem_index  out  s_index  latched miss set
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, miss serviced
- done_way  out  3  way installed; valid when done=1

## Operation
- Storage: valid[set][way], dirty[set][way] flops; a victim register (3 bits) and an index register (s_index bits).
- States: IDLE, SELECT, WB, FILL, INSTALL.
- IDLE: req=1 -> latch req_index/req_write, go to SELECT.
- SELECT: lru_index = latched index; choose victim (see Configuration) and latch it. If valid & dirty for the victim, go to WB; otherwise go to FILL.
- WB: wb_req=1. On wb_ack=1, clear dirty for the victim and go to FILL.
- FILL: fill_req=1. On fill_ack=1, go to INSTALL.
- INSTALL: set valid=1 and dirty=req_write for the victim. lru_load=1, lru_index=latched index, lru_access=victim. done=1, done_way=victim. Go to IDLE.
- Hit, in any state: lru_load=1, lru_index=hit_index, lru_access=hit_way, combinational in the same cycle. If hit_write=1, dirty for (hit_index, hit_way) is set at the next edge.
- Simultaneous hit and INSTALL:
  - The INSTALL update owns the lru_* port; the hit's LRU update is dropped.
  - The hit's dirty set is still applied.
  - If the hit targets the same set and way as the install, dirty = req_write | hit_write.
- lru_index otherwise follows the latched index (SELECT/WB/FILL) so plru is stable; in IDLE it follows req_index.
- Acks outside their state are ignored.
- The datapath must not issue a hit to the way being evicted while busy.

## Timing
- Reset (rst=0 at an edge): state = IDLE. All valid/dirty = 0; victim and index registers = 0.
- Output values after reset: wb_req, fill_req, lru_load, busy and done are 0; mem_way, mem_index and done_way are 0.
- rst=0 mid-operation (including WB/FILL): the request is abandoned with no done pulse. Requests drop on the next cycle.
- Clean miss with zero-wait ack (fill_ack high in the first FILL cycle):
  - req accepted at cycle 0; SELECT at cycle 1.
  - FILL at cycle 2; INSTALL/done at cycle 3.
  - Each wait cycle on an ack adds 1 cycle.
- Dirty miss with zero-wait acks: done at cycle 4.
- wb_req/fill_req are decoded from the state register and are glitch-free. They deassert in the cycle after the ack.
- req held high after done: a new miss is accepted the cycle after INSTALL (back in IDLE).

## Configuration
- LRU_EVICT_INVALID_FIRST_EN defined:
  - In SELECT, if any way of the set is invalid, the victim is the lowest-numbered invalid way; plru is ignored.
  - If all ways are valid, the victim is plru.
- Not defined: the victim is always plru. Installs into invalid ways happen only when pLRU points there.

## Test plan
- Reset, then miss on set 2 with plru=5, fill_ack zero-wait -> fill_req at cycle 2; done at cycle 3 with done_way=5; lru_load with lru_access=5, lru_index=2; valid[2][5]=1; no wb_req.
- Store miss to set 1 (victim 3, installed dirty), then a second miss to set 1 with plru=3 -> wb_req with mem_way=3; on wb_ack, dirty cleared, then fill; done_way=3 at cycle 4 with zero-wait acks.
- Macro on: set 0 has ways 0–1 valid, plru=6 -> victim 2. Macro off: same setup -> victim 6.
- Hit (index 4, way 7, write) during FILL -> lru_load same cycle with lru_access=7; dirty[4][7]=1. Hit coincident with INSTALL -> only the install's lru update is seen.
- rst=0 during WB with wb_ack withheld -> next cycle wb_req=0, busy=0, all valid=0, no done.
- wb_ack/fill_ack pulsed while in IDLE -> no state change, no outputs.

Source files
------------

// File: rtl/lru_evict_ctrl_if.sv
// Miss/hit/memory handshake bundle for lru_evict_ctrl.
// slave = the controller, master = the datapath and memory side driving it.
`timescale 1ns/1ps
interface lru_evict_ctrl_if #(parameter int s_index = 3) ();
  logic               req;
  logic [s_index-1:0] req_index;
  logic               req_write;
  logic               hit;
  logic [s_index-1:0] hit_index;
  logic [2:0]         hit_way;
  logic               hit_write;
  logic [2:0]         plru;
  logic               lru_load;
  logic [s_index-1:0] lru_index;
  logic [2:0]         lru_access;
  logic               wb_req;
  logic               wb_ack;
  logic               fill_req;
  logic               fill_ack;
  logic [2:0]         mem_way;
  logic [s_index-1:0] mem_index;
  logic               busy;
  logic               done;
  logic [2:0]         done_way;

  modport slave (
    input  req, req_index, req_write, hit, hit_index, hit_way, hit_write,
           plru, wb_ack, fill_ack,
    output lru_load, lru_index, lru_access, wb_req, fill_req, mem_way,
           mem_index, busy, done, done_way
  );

  modport master (
    output req, req_index, req_write, hit, hit_index, hit_way, hit_write,
           plru, wb_ack, fill_ack,
    input  lru_load, lru_index, lru_access, wb_req, fill_req, mem_way,
           mem_index, busy, done, done_way
  );
endinterface

// File: rtl/lru_evict_ctrl.sv
// Miss-side eviction sequencer for an 8-way set-associative cache.
// Build option: LRU_EVICT_INVALID_FIRST_EN makes SELECT prefer the lowest invalid way over plru.
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | waiting for req; lru_index follows req_index
// S_SELECT  | pLRU tree addressed with latched set; victim latched
// S_WB      | wb_req high until wb_ack; dirty of victim then cleared
// S_FILL    | fill_req high until fill_ack
// S_INSTALL | victim marked valid, pLRU updated, done pulse
`timescale 1ns/1ps
module lru_evict_ctrl #(
  parameter int s_index = 3
) (
  input logic            clk,
  input logic            rst,
  lru_evict_ctrl_if.slave bus
);
  localparam int n_sets = 2 ** s_index;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WB,
    S_FILL,
    S_INSTALL
  } state_t;

  state_t                       state;
  logic [n_sets-1:0][7:0]       valid_q;
  logic [n_sets-1:0][7:0]       dirty_q;
  logic [s_index-1:0]           idx_q;
  logic [2:0]                   victim_q;
  logic                         wr_q;
  logic                         wb_req_q;
  logic                         fill_req_q;
  logic                         busy_q;
  logic                         done_q;
  logic [2:0]                   done_way_q;
  logic [2:0]                   pick;
  logic                         pick_dirty;
  logic                         hit_on_victim;

  always_comb begin
    pick = bus.plru;
`ifdef LRU_EVICT_INVALID_FIRST_EN
    for (int w = 7; w >= 0; w--) begin
      if (!valid_q[idx_q][w]) pick = 3'(w);
    end
`endif
  end

  assign pick_dirty    = valid_q[idx_q][pick] & dirty_q[idx_q][pick];
  assign hit_on_victim = bus.hit & bus.hit_write &
                         (bus.hit_index == idx_q) & (bus.hit_way == victim_q);

  // The install owns the pLRU port; a coincident hit only updates dirty.
  always_comb begin
    bus.lru_load   = 1'b0;
    bus.lru_index  = idx_q;
    bus.lru_access = victim_q;
    if (state == S_IDLE) bus.lru_index = bus.req_index;
    if (state == S_INSTALL) begin
      bus.lru_load   = 1'b1;
      bus.lru_index  = idx_q;
      bus.lru_access = victim_q;
    end else if (bus.hit) begin
      bus.lru_load   = 1'b1;
      bus.lru_index  = bus.hit_index;
      bus.lru_access = bus.hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      idx_q      <= '0;
      victim_q   <= '0;
      wr_q       <= 1'b0;
      wb_req_q   <= 1'b0;
      fill_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_way_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.hit && bus.hit_write) dirty_q[bus.hit_index][bus.hit_way] <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            idx_q  <= bus.req_index;
            wr_q   <= bus.req_write;
            busy_q <= 1'b1;
            state  <= S_SELECT;
          end
        end
        S_SELECT: begin
          victim_q <= pick;
          if (pick_dirty) begin
            wb_req_q <= 1'b1;
            state    <= S_WB;
          end else begin
            fill_req_q <= 1'b1;
            state      <= S_FILL;
          end
        end
        S_WB: begin
          if (bus.wb_ack) begin
            dirty_q[idx_q][victim_q] <= 1'b0;
            wb_req_q   <= 1'b0;
            fill_req_q <= 1'b1;
            state      <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.fill_ack) begin
            fill_req_q <= 1'b0;
            done_q     <= 1'b1;
            done_way_q <= victim_q;
            state      <= S_INSTALL;
          end
        end
        S_INSTALL: begin
          valid_q[idx_q][victim_q] <= 1'b1;
          dirty_q[idx_q][victim_q] <= wr_q | hit_on_victim;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.wb_req    = wb_req_q;
  assign bus.fill_req  = fill_req_q;
  assign bus.mem_way   = victim_q;
  assign bus.mem_index = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_way  = done_way_q;
endmodule
